// File: rtl/sel_code_encoder_if.sv
// sel_code_encoder_if
// Purpose : groups the request/result handshake of sel_code_encoder.
// Signals : in_valid/in_ready/req  - upstream request channel
//           out_valid/out_ready    - downstream result handshake
//           code/multi_hot         - held result
//           err_cnt                - saturating malformed-request counter
// Modports: slave  - the encoder side
//           master - the side that drives requests and consumes results
interface sel_code_encoder_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           req;
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           code;
  logic                 multi_hot;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport slave (
    input  in_valid, req, out_ready,
    output in_ready, out_valid, code, multi_hot, err_cnt
  );

  modport master (
    output in_valid, req, out_ready,
    input  in_ready, out_valid, code, multi_hot, err_cnt
  );
endinterface

// File: rtl/sel_code_encoder.sv
// sel_code_encoder
// Purpose : one-deep registered priority encoder for a 4-bit selector
//           request. Lowest set bit wins; vectors with more than one bit
//           set are flagged, and zero or multi-hot requests are counted.
// Ports   : clk - clock, rising edge
//           rst - asynchronous, active-high reset
//           bus - sel_code_encoder_if.slave (handshake, result, err_cnt)
module sel_code_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  sel_code_encoder_if.slave      bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t               state_q;
  logic [1:0]           code_q;
  logic                 multi_hot_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic       in_ready;
  logic       accept;
  logic       drain;
  logic       req_zero;
  logic       req_multi;
  logic       valid_accept;
  logic       err_event;
  logic [1:0] code_d;

  // in_ready looks only at state and out_ready, never at in_valid/req,
  // so no combinational path exists from the request side back to it.
  assign in_ready     = (state_q == EMPTY) || bus.out_ready;
  assign accept       = bus.in_valid && in_ready;
  assign drain        = (state_q == FULL) && bus.out_ready;
  assign req_zero     = (bus.req == 4'd0);
  // Clearing the lowest set bit leaves something only if 2+ bits were set.
  assign req_multi    = ((bus.req & (bus.req - 4'd1)) != 4'd0);
  assign valid_accept = accept && !req_zero;
  assign err_event    = accept && (req_zero || req_multi);

  always_comb begin
    code_d = 2'b00;
    if (bus.req[0])      code_d = 2'b00;
    else if (bus.req[1]) code_d = 2'b01;
    else if (bus.req[2]) code_d = 2'b10;
    else if (bus.req[3]) code_d = 2'b11;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      code_q      <= 2'b00;
      multi_hot_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (err_event && (err_cnt_q != ERR_MAX)) begin
        err_cnt_q <= err_cnt_q + ERR_ONE;
      end

      case (state_q)
        EMPTY: begin
          if (valid_accept) begin
            state_q     <= FULL;
            code_q      <= code_d;
            multi_hot_q <= req_multi;
          end
        end
        FULL: begin
          // Without drain, in_ready is low, so nothing can be accepted and
          // the held result stays put.
          if (drain) begin
            if (valid_accept) begin
              code_q      <= code_d;
              multi_hot_q <= req_multi;
            end else begin
              // A zero request drained alongside leaves code/multi_hot alone.
              state_q <= EMPTY;
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.code      = code_q;
  assign bus.multi_hot = multi_hot_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sel_code_encoder.sv
// tb_sel_code_encoder
// Purpose : directed self-checking bench for sel_code_encoder. A default
//           instance (8-bit error counter) covers the handshake and
//           encoding behaviour; a second instance with a 2-bit counter
//           covers saturation.
module tb_sel_code_encoder;

  logic clk;
  logic rst;

  int chk_cnt;
  int pass_cnt;

  sel_code_encoder_if #(.ERR_CNT_W(8)) bus8 ();
  sel_code_encoder_if #(.ERR_CNT_W(2)) bus2 ();

  sel_code_encoder #(.ERR_CNT_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  sel_code_encoder #(.ERR_CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] stream_req  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [1:0] stream_code [8] = '{2'b00, 2'b01, 2'b10, 2'b11,
                                  2'b11, 2'b10, 2'b01, 2'b00};
  logic [1:0] sat_exp     [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;

    // Reset held across edges with a request pending: nothing accepted.
    rst            = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.req       = 4'b0001;
    bus8.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.req       = 4'b0000;
    bus2.out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_code",      32'(bus8.code),      32'd0);
    check("rst_multi_hot", 32'(bus8.multi_hot), 32'd0);
    check("rst_err_cnt",   32'(bus8.err_cnt),   32'd0);
    check("rst_in_ready",  32'(bus8.in_ready),  32'd1);
    check("rst_err_cnt2",  32'(bus2.err_cnt),   32'd0);
    $display("reset: out_valid=%0b code=%0b in_ready=%0b", bus8.out_valid, bus8.code, bus8.in_ready);

    // First edge after deassertion accepts the pending request.
    #2;
    rst = 1'b0;
    tick();
    check("post_rst_valid", 32'(bus8.out_valid), 32'd1);
    check("post_rst_code",  32'(bus8.code),      32'd0);
    bus8.in_valid = 1'b0;
    tick();
    check("post_rst_drain", 32'(bus8.out_valid), 32'd0);

    // One-hot streaming: a result on every cycle, no bubbles, no errors.
    for (int i = 0; i < 8; i++) begin
      bus8.in_valid = 1'b1;
      bus8.req      = stream_req[i];
      tick();
      check("stream_valid",    32'(bus8.out_valid), 32'd1);
      check("stream_code",     32'(bus8.code),      32'(stream_code[i]));
      check("stream_multi",    32'(bus8.multi_hot), 32'd0);
      check("stream_in_ready", 32'(bus8.in_ready),  32'd1);
      $display("stream %0d: req=%b code=%b multi_hot=%0b", i, stream_req[i], bus8.code, bus8.multi_hot);
    end
    bus8.in_valid = 1'b0;
    tick();
    check("stream_end_valid", 32'(bus8.out_valid), 32'd0);
    check("stream_err_cnt",   32'(bus8.err_cnt),   32'd0);

    // Backpressure: hold 0100 while 1000 waits upstream.
    bus8.in_valid  = 1'b1;
    bus8.req       = 4'b0100;
    bus8.out_ready = 1'b0;
    tick();
    check("bp_valid", 32'(bus8.out_valid), 32'd1);
    check("bp_code",  32'(bus8.code),      32'd2);
    bus8.req = 4'b1000;
    #1;
    check("bp_in_ready_low", 32'(bus8.in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 32'(bus8.out_valid), 32'd1);
      check("bp_hold_code",  32'(bus8.code),      32'd2);
      check("bp_hold_ready", 32'(bus8.in_ready),  32'd0);
      $display("bp hold %0d: code=%b in_ready=%0b", i, bus8.code, bus8.in_ready);
    end
    bus8.out_ready = 1'b1;
    #1;
    check("bp_in_ready_pass", 32'(bus8.in_ready), 32'd1);
    tick();
    check("bp_swap_valid", 32'(bus8.out_valid), 32'd1);
    check("bp_swap_code",  32'(bus8.code),      32'd3);
    $display("bp release: code=%b", bus8.code);
    bus8.in_valid = 1'b0;
    tick();
    check("bp_end_valid", 32'(bus8.out_valid), 32'd0);
    check("bp_err_cnt",   32'(bus8.err_cnt),   32'd0);

    // Malformed input: multi-hot then zero.
    pulse_reset();
    bus8.in_valid = 1'b1;
    bus8.req      = 4'b0110;
    tick();
    check("mal_valid",   32'(bus8.out_valid), 32'd1);
    check("mal_code",    32'(bus8.code),      32'd1);
    check("mal_multi",   32'(bus8.multi_hot), 32'd1);
    check("mal_err1",    32'(bus8.err_cnt),   32'd1);
    $display("malformed 0110: code=%b multi_hot=%0b err_cnt=%0d", bus8.code, bus8.multi_hot, bus8.err_cnt);
    bus8.req = 4'b0000;
    tick();
    check("zero_valid",  32'(bus8.out_valid), 32'd0);
    check("zero_code",   32'(bus8.code),      32'd1);
    check("zero_multi",  32'(bus8.multi_hot), 32'd1);
    check("zero_err2",   32'(bus8.err_cnt),   32'd2);
    $display("malformed 0000: out_valid=%0b err_cnt=%0d", bus8.out_valid, bus8.err_cnt);
    bus8.in_valid = 1'b0;
    tick();
    check("zero_idle_valid", 32'(bus8.out_valid), 32'd0);

    // Saturation on the 2-bit counter instance.
    bus2.in_valid = 1'b1;
    bus2.req      = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sat_err_cnt", 32'(bus2.err_cnt),   32'(sat_exp[i]));
      check("sat_valid",   32'(bus2.out_valid), 32'd0);
      $display("sat %0d: err_cnt=%0d", i, bus2.err_cnt);
    end
    bus2.in_valid = 1'b0;

    // Asynchronous reset while holding code 11 with err_cnt 1.
    pulse_reset();
    bus8.in_valid  = 1'b1;
    bus8.req       = 4'b0000;
    bus8.out_ready = 1'b0;
    tick();
    bus8.req = 4'b1000;
    tick();
    bus8.in_valid = 1'b0;
    tick();
    check("hold_valid", 32'(bus8.out_valid), 32'd1);
    check("hold_code",  32'(bus8.code),      32'd3);
    check("hold_err",   32'(bus8.err_cnt),   32'd1);
    rst = 1'b1;
    #1;
    check("arst_valid",    32'(bus8.out_valid), 32'd0);
    check("arst_code",     32'(bus8.code),      32'd0);
    check("arst_err",      32'(bus8.err_cnt),   32'd0);
    check("arst_in_ready", 32'(bus8.in_ready),  32'd1);
    $display("async rst: out_valid=%0b code=%b err_cnt=%0d", bus8.out_valid, bus8.code, bus8.err_cnt);
    #1;
    rst = 1'b0;
    tick();
    check("arst_after_valid", 32'(bus8.out_valid), 32'd0);
    check("arst_after_code",  32'(bus8.code),      32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sel_code_encoder.md
SEL_CODE_ENCODER -- requirements
Module: sel_code_encoder

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, giving the width of the error counter (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream request vector is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts req this cycle.
REQ-006 SHALL have port req, input, 4 bits: request vector to encode (intended one-hot).
REQ-007 SHALL have port out_valid, output, 1 bit: code and multi_hot hold a valid result.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-009 SHALL have port code, output, 2 bits: encoded selector.
REQ-010 SHALL have port multi_hot, output, 1 bit: the result came from a vector with more than one bit set.
REQ-011 SHALL have port err_cnt, output, ERR_CNT_W bits: saturating count of malformed requests.

Function
REQ-012 SHALL implement a two-state FSM: EMPTY (no held result) and FULL (result held, out_valid=1).
REQ-013 SHALL define accept = in_valid && in_ready and drain = out_valid && out_ready.
REQ-014 SHALL drive in_ready = 1 in EMPTY; in FULL, in_ready = out_ready (combinational pass-through, no bubble).
REQ-015 SHALL encode with lowest-index priority: req[0]->2'b00, req[1]->2'b01, req[2]->2'b10, req[3]->2'b11.
REQ-016 SHALL register code and multi_hot on the accept edge; latency is 1 cycle from accept to out_valid=1.
REQ-017 SHALL set multi_hot=1 when the accepted req has 2 or more bits set, and 0 otherwise.
REQ-018 SHALL consume an accepted req==4'b0000 without producing a result: the FSM takes the drain-only path (FULL+drain -> EMPTY, EMPTY stays EMPTY), and code and multi_hot are unchanged.
REQ-019 SHALL transition as follows (a "valid accept" is an accept with req!=0):
- EMPTY + valid accept -> FULL.
- FULL + drain with no valid accept -> EMPTY.
- FULL + drain + valid accept -> FULL with new data.
- FULL with no drain -> hold all outputs stable.
REQ-020 SHALL hold code and multi_hot stable while out_valid=1 and out_ready=0, regardless of in_valid or req.
REQ-021 SHALL increment err_cnt by 1 on each accept with req==0 or multi-hot req, saturating at all-ones (no wrap).
REQ-022 SHALL not increment err_cnt for a one-hot accept or for a cycle without accept.
REQ-023 SHALL make in_ready independent of in_valid and req (no combinational loop on the input side).

Reset
REQ-024 SHALL, while rst=1, immediately force the FSM to EMPTY, out_valid=0, code=2'b00, multi_hot=0 and err_cnt=0.
REQ-025 SHALL, on rst assertion mid-transfer, discard any held result without a drain handshake.
REQ-026 SHALL drive in_ready=1 during reset and accept no data until the first rising clk edge after rst deasserts.

Verification
REQ-027 One-hot sequence: send req=0001, 0010, 0100, 1000 with out_ready=1 -> codes 00, 01, 10, 11 each one cycle later, multi_hot=0, err_cnt=0.
REQ-028 Backpressure: accept req=0100, hold out_ready=0 for 5 cycles while driving req=1000 -> in_ready=0 and code stays 10; on out_ready=1, 10 drains and 11 is captured in the same cycle.
REQ-029 Malformed input: send req=0110 then req=0000 -> first yields code=01 with multi_hot=1; second produces no out_valid; err_cnt=2.
REQ-030 Saturation: with ERR_CNT_W=2, send 5 zero requests -> err_cnt reads 1, 2, 3, 3, 3.
REQ-031 Async reset mid-hold: FULL with code=11 and err_cnt=1, pulse rst between clock edges -> out_valid=0, code=00, err_cnt=0 before the next edge.
REQ-032 Streaming: in_valid=1 and out_ready=1 continuously over 8 one-hot requests -> 8 results on 8 consecutive cycles, no bubbles.
